latch_seq: RTL and testbench

LATCH_SEQ -- requirements
Module: latch_seq

---
 rtl/latch_seq.sv | 170 +++++++++++++++++
 tb/tb_latch_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_seq.sv
// latch_seq: D-latch characterisation sequencer; drives D/E per pattern bit and checks the fed-back Q.
// Optional macro LATCH_SEQ_HOLD_CHECK_EN adds a HOLD phase per bit that checks Q against a complemented D.
module latch_seq #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned E_WIDTH   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_WIDTH - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_SAMPLE,
`ifdef LATCH_SEQ_HOLD_CHECK_EN
    S_HOLD,
`endif
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       pattern, pattern_nxt;
  logic [2:0]       err_cnt, err_nxt;
  logic             d_out, e_out, busy, done, pass;
  logic             d_nxt, e_nxt, busy_nxt, done_nxt, pass_nxt;
  logic             start_s1, start_s2, start_s3;
  logic             q_s1, q_s2;
  logic             start_evt;

  wire unused_ui = &{1'b0, ui_in[7:2]};

  assign start_evt = start_s2 & ~start_s3;
  assign uo_out    = {err_cnt, pass, done, busy, e_out, d_out};
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;

  // State, datapath, synchronizers and registered outputs; ena freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= 3'd7;
      pattern  <= 8'h00;
      err_cnt  <= 3'd0;
      d_out    <= 1'b0;
      e_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      q_s1     <= 1'b0;
      q_s2     <= 1'b0;
    end else if (ena) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      pattern  <= pattern_nxt;
      err_cnt  <= err_nxt;
      d_out    <= d_nxt;
      e_out    <= e_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      start_s1 <= ui_in[0];
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      q_s1     <= ui_in[1];
      q_s2     <= q_s1;
    end
  end

  // Next state plus next output values, so outputs line up with the state they describe.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    idx_nxt     = idx;
    pattern_nxt = pattern;
    err_nxt     = err_cnt;

    unique case (state)
      S_IDLE, S_DONE: begin
        cnt_nxt = '0;
        if (start_evt) begin
          pattern_nxt = uio_in;
          idx_nxt     = 3'd7;
          err_nxt     = 3'd0;
          state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (cnt == CHECK_LAST) begin
          cnt_nxt = '0;
          if ((q_s2 != pattern[idx]) && (err_cnt != 3'd7)) err_nxt = err_cnt + 3'd1;
`ifdef LATCH_SEQ_HOLD_CHECK_EN
          state_nxt = S_HOLD;
`else
          state_nxt = S_NEXT;
`endif
        end
      end
`ifdef LATCH_SEQ_HOLD_CHECK_EN
      S_HOLD: begin
        if (cnt == CHECK_LAST) begin
          cnt_nxt = '0;
          if ((q_s2 != pattern[idx]) && (err_cnt != 3'd7)) err_nxt = err_cnt + 3'd1;
          state_nxt = S_NEXT;
        end
      end
`endif
      S_NEXT: begin
        cnt_nxt = '0;
        if (idx == 3'd0) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx - 3'd1;
          state_nxt = S_SETUP;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase

    d_nxt    = 1'b0;
    e_nxt    = (state_nxt == S_PULSE);
    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    done_nxt = (state_nxt == S_DONE);
    pass_nxt = (state_nxt == S_DONE) && (err_nxt == 3'd0);

    unique case (state_nxt)
      S_SETUP, S_PULSE:  d_nxt = pattern_nxt[idx_nxt];
      S_SAMPLE, S_NEXT:  d_nxt = d_out;
`ifdef LATCH_SEQ_HOLD_CHECK_EN
      S_HOLD:            d_nxt = ~pattern_nxt[idx_nxt];
`endif
      default:           d_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_latch_seq.sv
// tb_latch_seq: scoreboard bench for latch_seq; stimulus pushes expected run results, a monitor checks each DONE.
module tb_latch_seq;

  localparam int unsigned SETUP_CYC = 1;
  localparam int unsigned E_WIDTH   = 2;
`ifdef LATCH_SEQ_HOLD_CHECK_EN
  localparam int unsigned BIT_LEN = SETUP_CYC + E_WIDTH + 7;
`else
  localparam int unsigned BIT_LEN = SETUP_CYC + E_WIDTH + 4;
`endif
  localparam int unsigned RUN_LEN = 8 * BIT_LEN;

  typedef struct {
    int err;
    int pass;
    int dseq;
    int pulses;
    int e_hi;
    int busy_len;
  } exp_t;

  exp_t exp_q[$];

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] uio_in;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       q_lat;
  logic       q_in;
  int         q_mode;

  int checks;
  int failures;
  int done_seen;
  int e_rises;

  wire d_out = uo_out[0];
  wire e_out = uo_out[1];
  wire busy  = uo_out[2];
  wire done  = uo_out[3];
  wire pass  = uo_out[4];
  wire [2:0] err_cnt = uo_out[7:5];

  latch_seq #(.SETUP_CYC(SETUP_CYC), .E_WIDTH(E_WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural D latch, transparent while E is high.
  always @(e_out or d_out) if (e_out) q_lat = d_out;

  assign q_in  = (q_mode == 0) ? q_lat : (q_mode == 1) ? 1'b0 : d_out;
  assign ui_in = {6'b000000, q_in, start};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: collects per-run observations and scores them against the queue on each DONE rise.
  logic prev_busy, prev_e, prev_done;
  int   m_busy_len, m_pulses, m_e_hi;
  logic [7:0] m_dseq;
  initial begin
    prev_busy = 1'b0; prev_e = 1'b0; prev_done = 1'b0;
    m_busy_len = 0; m_pulses = 0; m_e_hi = 0; m_dseq = 8'h00;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        m_busy_len = 0; m_pulses = 0; m_e_hi = 0; m_dseq = 8'h00;
      end
      if (busy) m_busy_len++;
      if (e_out) m_e_hi++;
      if (e_out && !prev_e) begin
        m_pulses++;
        e_rises++;
        m_dseq = {m_dseq[6:0], d_out};
      end
      if (done && !prev_done) begin
        exp_t e;
        done_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("err_cnt", int'(err_cnt), e.err);
          check("pass", int'(pass), e.pass);
          check("d_sequence", int'(m_dseq), e.dseq);
          check("e_pulses", m_pulses, e.pulses);
          check("e_high_cycles", m_e_hi, e.e_hi);
          check("busy_cycles", m_busy_len, e.busy_len);
        end
      end
      prev_busy = busy;
      prev_e    = e_out;
      prev_done = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(3);
    start = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 50) begin tick(1); n++; end
    if (!busy) check(name, 0, 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 1000) begin tick(1); n++; end
    if (!done) check(name, 0, 1);
  endtask

  task automatic push_exp(input int err, input int ps, input int dseq, input int extra);
    exp_t e;
    e.err      = err;
    e.pass     = ps;
    e.dseq     = dseq;
    e.pulses   = 8;
    e.e_hi     = 8 * E_WIDTH + extra;
    e.busy_len = RUN_LEN + extra;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [7:0] pat, input int mode, input string name);
    q_mode = mode;
    uio_in = pat;
    pulse_start();
    wait_busy({name, "_busy_timeout"});
    wait_done({name, "_done_timeout"});
    tick(4);
  endtask

  initial begin
    logic [7:0] snap;
    int         rise_snap;
    checks = 0; failures = 0; done_seen = 0; e_rises = 0;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; uio_in = 8'h00; q_mode = 0;
    tick(3);
    check("reset_uo_out", int'(uo_out), 0);
    check("reset_uio_out", int'(uio_out), 0);
    check("reset_uio_oe", int'(uio_oe), 0);
    rst_n = 1'b1;
    tick(3);
    check("idle_uo_out", int'(uo_out), 0);

    // Latch model, 0xA5: clean pass.
    push_exp(0, 1, 8'hA5, 0);
    run(8'hA5, 0, "a5_latch");

    // Q stuck at 0 with 0xFF: error count saturates at 7.
    push_exp(7, 0, 8'hFF, 0);
    run(8'hFF, 1, "ff_stuck0");

    // Second start mid-run with a different pattern must be ignored.
    push_exp(0, 1, 8'h3C, 0);
    q_mode = 0;
    uio_in = 8'h3C;
    pulse_start();
    wait_busy("3c_busy_timeout");
    tick(20);
    uio_in = 8'h00;
    pulse_start();
    wait_done("3c_done_timeout");
    tick(4);

    // Transparent wire: only the complemented-D hold check can catch it.
`ifdef LATCH_SEQ_HOLD_CHECK_EN
    push_exp(7, 0, 8'hA5, 0);
`else
    push_exp(0, 1, 8'hA5, 0);
`endif
    run(8'hA5, 2, "a5_wire");

    // Stall for 10 cycles during a PULSE: outputs frozen, run 10 cycles longer.
    push_exp(0, 1, 8'h96, 10);
    q_mode = 0;
    uio_in = 8'h96;
    pulse_start();
    wait_busy("stall_busy_timeout");
    begin
      int n = 0;
      while (!e_out && n < 50) begin tick(1); n++; end
    end
    check("stall_in_pulse", int'(e_out), 1);
    snap = uo_out;
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall_uo_out_frozen", int'(uo_out), int'(snap));
    end
    ena = 1'b1;
    wait_done("stall_done_timeout");
    tick(4);

    // Reset 30 cycles into a run: everything clears and stays idle.
    q_mode = 0;
    uio_in = 8'hFF;
    pulse_start();
    wait_busy("rst_busy_timeout");
    tick(30);
    rst_n = 1'b0;
    tick(1);
    check("midrun_reset_uo_out", int'(uo_out), 0);
    rst_n = 1'b1;
    rise_snap = e_rises;
    tick(100);
    check("post_reset_no_e_pulse", e_rises, rise_snap);
    check("post_reset_uo_out", int'(uo_out), 0);

    tick(2);
    check("scoreboard_drained", exp_q.size(), 0);
    check("done_count", done_seen, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
